ex_stage: RTL and testbench

//  Execute stage, directly downstream of the ID/EX pipeline register; consumes its alusel/aluop/reg1/reg2/wd/wreg.

---
 rtl/ex_stage_pkg.sv | 53 +++++
 rtl/ex_stage_div_iter.sv | 129 ++++++++++++
 rtl/ex_stage.sv | 164 ++++++++++++++++
 tb/tb_ex_stage.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ex_stage_pkg
//  Purpose  : Shared definitions for the execute stage. These are the ALU class
//             and sub-op codes, the bus widths, the ZERO_WORD constant and the
//             divider state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package ex_stage_pkg;

    localparam int          DATA_W    = 32;
    localparam int          DIV_STEPS = 32;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // ALU class codes (alusel)
    localparam logic [2:0] RES_NOP   = 3'b000;
    localparam logic [2:0] RES_LOGIC = 3'b001;
    localparam logic [2:0] RES_SHIFT = 3'b010;
    localparam logic [2:0] RES_MOVE  = 3'b011;
    localparam logic [2:0] RES_ARITH = 3'b100;

    // ALU sub-op codes (aluop)
    localparam logic [7:0] OP_NOP  = 8'b0000_0000;
    localparam logic [7:0] OP_AND  = 8'b0010_0100;
    localparam logic [7:0] OP_OR   = 8'b0010_0101;
    localparam logic [7:0] OP_XOR  = 8'b0010_0110;
    localparam logic [7:0] OP_NOR  = 8'b0010_0111;
    localparam logic [7:0] OP_SLL  = 8'b0111_1100;
    localparam logic [7:0] OP_SRL  = 8'b0000_0010;
    localparam logic [7:0] OP_SRA  = 8'b0000_0011;
    localparam logic [7:0] OP_ADD  = 8'b0010_0000;
    localparam logic [7:0] OP_ADDU = 8'b0010_0001;
    localparam logic [7:0] OP_SUB  = 8'b0010_0010;
    localparam logic [7:0] OP_SUBU = 8'b0010_0011;
    localparam logic [7:0] OP_SLT  = 8'b0010_1010;
    localparam logic [7:0] OP_SLTU = 8'b0010_1011;
    localparam logic [7:0] OP_MFHI = 8'b0001_0000;
    localparam logic [7:0] OP_MTHI = 8'b0001_0001;
    localparam logic [7:0] OP_MFLO = 8'b0001_0010;
    localparam logic [7:0] OP_MTLO = 8'b0001_0011;
    localparam logic [7:0] OP_DIV  = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU = 8'b0001_1011;

    // Divider FSM encoding
    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_t;

endpackage
`default_nettype wire

// File: rtl/ex_stage_div_iter.sv
`default_nettype none
// ============================================================================
//  Module   : div_iter
//  Purpose  : Iterative radix-2 restoring divider that produces one quotient
//             bit per cycle. Signed operands are divided by magnitude, and the
//             signs are fixed up at the last step.
//  Config   : EX_DIV_ZERO_FAST_EN - a zero divisor takes a short path that
//             returns hi=lo=0.
//  Revision : 1.0 - initial release
// ============================================================================
module div_iter
    import ex_stage_pkg::*;
#(
    parameter int DIV_STEPS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        annul,
    input  logic        signed_div,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    output logic [31:0] result_hi,
    output logic [31:0] result_lo,
    output logic        ready
);

    localparam logic [5:0] LAST_STEP = 6'(DIV_STEPS - 1);

    div_state_t  state;
    div_state_t  state_next;
    logic [5:0]  count;
    logic [64:0] dividend;
    logic [64:0] step_next;
    logic [31:0] divisor;
    logic [32:0] partial;
    logic [31:0] diff;
    logic        neg_quot;
    logic        neg_rem;
    logic [31:0] abs1;
    logic [31:0] abs2;

    assign abs1  = (signed_div && opdata1[31]) ? (~opdata1 + 32'd1) : opdata1;
    assign abs2  = (signed_div && opdata2[31]) ? (~opdata2 + 32'd1) : opdata2;
    assign ready = (state == DIV_END);

    // One restoring step. The partial remainder is 33 bits wide so that a divisor of 2^31 or more cannot lose a bit.
    always_comb begin
        partial = dividend[64:32];
        diff    = partial[31:0] - divisor;
        if (partial >= {1'b0, divisor}) begin
            step_next = {diff, dividend[31:0], 1'b1};
        end else begin
            step_next = {dividend[63:0], 1'b0};
        end
    end

    // Next-state logic. annul overrides every other transition.
    always_comb begin
        state_next = state;
        if (annul) begin
            state_next = DIV_FREE;
        end else begin
            case (state)
                DIV_FREE: begin
                    if (start) begin
`ifdef EX_DIV_ZERO_FAST_EN
                        state_next = (opdata2 == ZERO_WORD) ? DIV_BY_ZERO : DIV_ON;
`else
                        state_next = DIV_ON;
`endif
                    end
                end
`ifdef EX_DIV_ZERO_FAST_EN
                DIV_BY_ZERO: state_next = DIV_END;
`endif
                DIV_ON:  if (count == LAST_STEP) state_next = DIV_END;
                DIV_END: if (!start) state_next = DIV_FREE;
                default: state_next = DIV_FREE;
            endcase
        end
    end

    // State register, operand load, iteration and result capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= DIV_FREE;
            count     <= 6'd0;
            dividend  <= '0;
            divisor   <= ZERO_WORD;
            neg_quot  <= 1'b0;
            neg_rem   <= 1'b0;
            result_hi <= ZERO_WORD;
            result_lo <= ZERO_WORD;
        end else begin
            state <= state_next;
            case (state)
                DIV_FREE: begin
                    if (start && !annul) begin
                        dividend <= {32'd0, abs1, 1'b0};
                        divisor  <= abs2;
                        count    <= 6'd0;
                        neg_quot <= signed_div & (opdata1[31] ^ opdata2[31]);
                        neg_rem  <= signed_div & opdata1[31];
                    end
                end
`ifdef EX_DIV_ZERO_FAST_EN
                DIV_BY_ZERO: begin
                    result_hi <= ZERO_WORD;
                    result_lo <= ZERO_WORD;
                end
`endif
                DIV_ON: begin
                    if (!annul) begin
                        dividend <= step_next;
                        count    <= count + 6'd1;
                        if (count == LAST_STEP) begin
                            result_lo <= neg_quot ? (~step_next[31:0] + 32'd1) : step_next[31:0];
                            result_hi <= neg_rem ? (~step_next[64:33] + 32'd1) : step_next[64:33];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ex_stage
//  Purpose  : Execute stage. Single-cycle ALU ops resolve combinationally.
//             DIV/DIVU run on the iterative divider, and the stage stalls the
//             front of the pipeline while a divide is in flight.
//  Config   : EX_DIV_ZERO_FAST_EN - fast path for a zero divisor (in div_iter).
//  Revision : 1.0 - initial release
// ============================================================================
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DIV_STEPS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  alusel_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        annul_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_o
);

    logic [31:0] logic_res;
    logic [31:0] shift_res;
    logic [31:0] move_res;
    logic [31:0] arith_res;
    logic [31:0] sum;
    logic [31:0] diff;
    logic        add_ov;
    logic        sub_ov;
    logic        is_div;
    logic        div_start;
    logic        div_ready;
    logic [31:0] div_hi;
    logic [31:0] div_lo;

    assign sum    = reg1_i + reg2_i;
    assign diff   = reg1_i - reg2_i;
    assign add_ov = (reg1_i[31] == reg2_i[31]) && (sum[31] != reg1_i[31]);
    assign sub_ov = (reg1_i[31] != reg2_i[31]) && (diff[31] != reg1_i[31]);
    assign is_div = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);

    // The start request is masked by reset so that a reset in mid-divide drops the stall at once.
    assign div_start  = rst && is_div && !annul_i;
    assign stallreq_o = div_start && !div_ready;
    assign wd_o       = wd_i;

    div_iter #(
        .DIV_STEPS (DIV_STEPS)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .start      (div_start),
        .annul      (annul_i),
        .signed_div (aluop_i == OP_DIV),
        .opdata1    (reg1_i),
        .opdata2    (reg2_i),
        .result_hi  (div_hi),
        .result_lo  (div_lo),
        .ready      (div_ready)
    );

    // Bitwise logic results.
    always_comb begin
        logic_res = ZERO_WORD;
        case (aluop_i)
            OP_AND:  logic_res = reg1_i & reg2_i;
            OP_OR:   logic_res = reg1_i | reg2_i;
            OP_XOR:  logic_res = reg1_i ^ reg2_i;
            OP_NOR:  logic_res = ~(reg1_i | reg2_i);
            default: ;
        endcase
    end

    // Shifts: the amount comes from reg1, the value from reg2.
    always_comb begin
        shift_res = ZERO_WORD;
        case (aluop_i)
            OP_SLL:  shift_res = reg2_i << reg1_i[4:0];
            OP_SRL:  shift_res = reg2_i >> reg1_i[4:0];
            OP_SRA:  shift_res = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
            default: ;
        endcase
    end

    // HI/LO reads.
    always_comb begin
        move_res = ZERO_WORD;
        case (aluop_i)
            OP_MFHI: move_res = hi_i;
            OP_MFLO: move_res = lo_i;
            default: ;
        endcase
    end

    // Add/subtract and set-on-less-than.
    always_comb begin
        arith_res = ZERO_WORD;
        case (aluop_i)
            OP_ADD, OP_ADDU: arith_res = sum;
            OP_SUB, OP_SUBU: arith_res = diff;
            OP_SLT:          arith_res = {31'd0, ($signed(reg1_i) < $signed(reg2_i))};
            OP_SLTU:         arith_res = {31'd0, (reg1_i < reg2_i)};
            default: ;
        endcase
    end

    // GPR write data select and write-enable suppression.
    always_comb begin
        wdata_o = ZERO_WORD;
        case (alusel_i)
            RES_LOGIC: wdata_o = logic_res;
            RES_SHIFT: wdata_o = shift_res;
            RES_MOVE:  wdata_o = move_res;
            RES_ARITH: wdata_o = arith_res;
            default: ;
        endcase
        wreg_o = wreg_i;
        if (((aluop_i == OP_ADD) && add_ov) || ((aluop_i == OP_SUB) && sub_ov) || is_div) begin
            wreg_o = 1'b0;
        end
    end

    // HI/LO writes from MTHI/MTLO and from a completed divide.
    always_comb begin
        whilo_o = 1'b0;
        hi_o    = ZERO_WORD;
        lo_o    = ZERO_WORD;
        case (aluop_i)
            OP_MTHI: begin
                whilo_o = 1'b1;
                hi_o    = reg1_i;
                lo_o    = lo_i;
            end
            OP_MTLO: begin
                whilo_o = 1'b1;
                hi_o    = hi_i;
                lo_o    = reg1_i;
            end
            OP_DIV, OP_DIVU: begin
                if (div_start && div_ready) begin
                    whilo_o = 1'b1;
                    hi_o    = div_hi;
                    lo_o    = div_lo;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_ex_stage
//  Purpose  : Self-checking bench for ex_stage. It uses directed corner cases
//             and randomized ALU and divide traffic, and compares each result
//             against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  alusel;
    logic [7:0]  aluop;
    logic [31:0] reg1, reg2, hi_in, lo_in;
    logic [4:0]  wd;
    logic        wreg, annul;
    logic [4:0]  wd_out;
    logic        wreg_out, whilo_out, stall;
    logic [31:0] wdata_out, hi_out, lo_out;

    int checks   = 0;
    int failures = 0;

    logic [7:0] alu_ops [18] = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA,
                                 OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_SLT, OP_SLTU,
                                 OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO, OP_NOP};
    logic [31:0] corners [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7};

    always #5 clk = ~clk;

    ex_stage dut (
        .clk        (clk),
        .rst        (rst_n),
        .alusel_i   (alusel),
        .aluop_i    (aluop),
        .reg1_i     (reg1),
        .reg2_i     (reg2),
        .wd_i       (wd),
        .wreg_i     (wreg),
        .hi_i       (hi_in),
        .lo_i       (lo_in),
        .annul_i    (annul),
        .wd_o       (wd_out),
        .wreg_o     (wreg_out),
        .wdata_o    (wdata_out),
        .whilo_o    (whilo_out),
        .hi_o       (hi_out),
        .lo_o       (lo_out),
        .stallreq_o (stall)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] sel_of(input logic [7:0] op);
        case (op)
            OP_AND, OP_OR, OP_XOR, OP_NOR:                            return RES_LOGIC;
            OP_SLL, OP_SRL, OP_SRA:                                   return RES_SHIFT;
            OP_MFHI, OP_MFLO:                                         return RES_MOVE;
            OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_SLT, OP_SLTU:        return RES_ARITH;
            default:                                                  return RES_NOP;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    task automatic drive(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        alusel = sel_of(op);
        aluop  = op;
        reg1   = a;
        reg2   = b;
        wd     = 5'($urandom);
        wreg   = 1'b1;
        hi_in  = $urandom;
        lo_in  = $urandom;
    endtask

    // Reference model for single-cycle ops, evaluated on the inputs currently applied.
    task automatic check_alu(input string tag);
        logic [31:0] ew, eh, el;
        logic        er, ehl;
        longint      s;
        ew = 32'h0; eh = 32'h0; el = 32'h0; er = wreg; ehl = 1'b0;
        case (aluop)
            OP_AND:  ew = reg1 & reg2;
            OP_OR:   ew = reg1 | reg2;
            OP_XOR:  ew = reg1 ^ reg2;
            OP_NOR:  ew = ~(reg1 | reg2);
            OP_SLL:  ew = reg2 << reg1[4:0];
            OP_SRL:  ew = reg2 >> reg1[4:0];
            OP_SRA:  begin s = longint'($signed(reg2)); s = s >>> reg1[4:0]; ew = s[31:0]; end
            OP_ADD, OP_ADDU, OP_SUB, OP_SUBU: begin
                if (aluop == OP_ADD || aluop == OP_ADDU) s = longint'($signed(reg1)) + longint'($signed(reg2));
                else                                     s = longint'($signed(reg1)) - longint'($signed(reg2));
                ew = s[31:0];
                if ((aluop == OP_ADD || aluop == OP_SUB) && (s != longint'($signed(s[31:0])))) er = 1'b0;
            end
            OP_SLT:  ew = ($signed(reg1) < $signed(reg2)) ? 32'd1 : 32'd0;
            OP_SLTU: ew = (reg1 < reg2) ? 32'd1 : 32'd0;
            OP_MFHI: ew = hi_in;
            OP_MFLO: ew = lo_in;
            OP_MTHI: begin ehl = 1'b1; eh = reg1;  el = lo_in; end
            OP_MTLO: begin ehl = 1'b1; eh = hi_in; el = reg1;  end
            default: ;
        endcase
        check({tag, " wdata"}, wdata_out, ew);
        check({tag, " wreg"},  32'(wreg_out), 32'(er));
        check({tag, " whilo"}, 32'(whilo_out), 32'(ehl));
        check({tag, " hi"},    hi_out, eh);
        check({tag, " lo"},    lo_out, el);
        check({tag, " stall"}, 32'(stall), 32'd0);
        check({tag, " wd"},    32'(wd_out), 32'(wd));
    endtask

    // Issue one divide, hold it in ID/EX while stalled, then check timing and the result.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eq, er;
        longint      q, r;
        int          stalls, exp_stalls;
        bit          check_vals;
        exp_stalls = 33;
        check_vals = 1'b1;
        if (b == 32'h0) begin
`ifdef EX_DIV_ZERO_FAST_EN
            eq = 32'h0; er = 32'h0; exp_stalls = 2;
`else
            eq = 32'hFFFF_FFFF; er = a; check_vals = !sgn;
`endif
        end else if (sgn) begin
            q  = longint'($signed(a)) / longint'($signed(b));
            r  = longint'($signed(a)) % longint'($signed(b));
            eq = q[31:0]; er = r[31:0];
        end else begin
            eq = a / b; er = a % b;
        end
        @(negedge clk);
        drive(sgn ? OP_DIV : OP_DIVU, a, b);
        #1;
        stalls = 0;
        while (stall === 1'b1 && stalls < 100) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        check({tag, " stall cycles"}, 32'(stalls), 32'(exp_stalls));
        check({tag, " whilo"}, 32'(whilo_out), 32'd1);
        check({tag, " wreg"},  32'(wreg_out), 32'd0);
        if (check_vals) begin
            check({tag, " lo"}, lo_out, eq);
            check({tag, " hi"}, hi_out, er);
        end
        @(negedge clk);
        drive(OP_NOP, 32'h0, 32'h0);
        #1;
        check({tag, " retire whilo"}, 32'(whilo_out), 32'd0);
        check({tag, " retire stall"}, 32'(stall), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; annul = 1'b0;
        alusel = RES_NOP; aluop = OP_NOP; reg1 = '0; reg2 = '0;
        wd = '0; wreg = 1'b0; hi_in = '0; lo_in = '0;
        repeat (3) @(negedge clk);
        check("reset wdata", wdata_out, 32'h0);
        check("reset wreg",  32'(wreg_out), 32'd0);
        check("reset whilo", 32'(whilo_out), 32'd0);
        check("reset hi",    hi_out, 32'h0);
        check("reset lo",    lo_out, 32'h0);
        check("reset stall", 32'(stall), 32'd0);
        rst_n = 1'b1;

        // Directed corner cases.
        @(negedge clk); drive(OP_ADD, 32'h7FFF_FFFF, 32'h1); #1;
        check("add ovf wdata", wdata_out, 32'h8000_0000);
        check("add ovf wreg", 32'(wreg_out), 32'd0);
        @(negedge clk); drive(OP_ADDU, 32'h7FFF_FFFF, 32'h1); #1;
        check("addu wreg", 32'(wreg_out), 32'd1);
        @(negedge clk); drive(OP_SRA, 32'd4, 32'hF000_0000); #1;
        check("sra", wdata_out, 32'hFF00_0000);
        @(negedge clk); drive(OP_SLT, 32'hFFFF_FFFF, 32'h1); #1;
        check("slt", wdata_out, 32'd1);
        @(negedge clk); drive(OP_SLTU, 32'hFFFF_FFFF, 32'h1); #1;
        check("sltu", wdata_out, 32'd0);
        @(negedge clk); drive(OP_SUB, 32'h0, 32'h8000_0000); #1;
        check_alu("sub ovf");

        // Randomized single-cycle traffic.
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            drive(alu_ops[$urandom_range(0, 17)], pick(), pick());
            #1;
            check_alu("rand alu");
        end

        // Directed divides.
        run_div("divu 100/7", 1'b0, 32'd100, 32'd7);
        run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_div("divu 5/0", 1'b0, 32'd5, 32'd0);
        run_div("divu big", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001);
        run_div("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);

        // Randomized divides with non-zero divisors.
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a, b;
            a = pick();
            b = pick();
            if (b == 32'h0) b = 32'd3;
            run_div("rand div", 1'($urandom_range(0, 1)), a, b);
        end

        // Annul in mid-divide, then a fresh divide.
        @(negedge clk); drive(OP_DIV, 32'hFFFF_FF9C, 32'd7); #1;
        repeat (10) begin @(negedge clk); #1; end
        check("annul pre stall", 32'(stall), 32'd1);
        annul = 1'b1; #1;
        check("annul stall", 32'(stall), 32'd0);
        check("annul whilo", 32'(whilo_out), 32'd0);
        @(negedge clk); annul = 1'b0; drive(OP_NOP, 32'h0, 32'h0); #1;
        check("post annul stall", 32'(stall), 32'd0);
        check("post annul whilo", 32'(whilo_out), 32'd0);
        run_div("after annul", 1'b1, 32'hFFFF_FF9C, 32'd7);

        // Asynchronous reset in mid-divide, then a fresh divide.
        @(negedge clk); drive(OP_DIVU, 32'd1000, 32'd9); #1;
        repeat (5) begin @(negedge clk); #1; end
        check("rst pre stall", 32'(stall), 32'd1);
        #1 rst_n = 1'b0; #1;
        check("rst stall", 32'(stall), 32'd0);
        check("rst whilo", 32'(whilo_out), 32'd0);
        @(negedge clk); drive(OP_NOP, 32'h0, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        run_div("after rst", 1'b0, 32'd1000, 32'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
